// File: rtl/lsu_mem_sequencer.sv
// ============================================================================
// Module  : lsu_mem_sequencer
// Brief   : Data-memory initiator; issues aligned accesses directly and splits
//           misaligned halfword/word accesses into byte cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_sequencer #(
    parameter int MEM_BYTES        = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] C_LIMIT = 32'(MEM_BYTES);
    localparam logic [2:0]  C_F3_SB = 3'b000;
    localparam logic [2:0]  C_F3_LBU = 3'b100;

    state_t      r_state, w_state;
    logic        r_load, w_load;
    logic        r_mis, w_mis_q;
    logic [2:0]  r_func3, w_func3_q;
    logic [31:0] r_addr, w_addr_q;
    logic [31:0] r_wdata, w_wdata_q;
    logic [1:0]  r_cnt, w_cnt;
    logic [1:0]  r_last, w_last;
    logic [31:0] r_acc, w_acc;

    logic        w_req_ready, w_resp_valid, w_resp_err;
    logic [31:0] w_resp_rdata;
    logic        w_mem_read, w_mem_write;
    logic [2:0]  w_mem_func3;
    logic [31:0] w_mem_addr, w_mem_wdata;

    // Request decode
    logic [1:0]  w_size_m1;
    logic        w_f3_ok, w_mis, w_req_err;
    logic [31:0] w_end;
    logic [1:0]  w_cnt_inc;
    logic [31:0] w_acc_ins;
    logic [31:0] w_acc_ext;

    always_comb begin
        w_size_m1 = 2'd0;
        w_f3_ok   = 1'b1;
        case (req_func3)
            3'b000, 3'b100: w_size_m1 = 2'd0;
            3'b001, 3'b101: w_size_m1 = 2'd1;
            3'b010:         w_size_m1 = 2'd3;
            default:        w_f3_ok   = 1'b0;
        endcase
        w_end = req_addr + {30'd0, w_size_m1};
        w_mis = ((w_size_m1 == 2'd1) && req_addr[0]) ||
                ((w_size_m1 == 2'd3) && (req_addr[1:0] != 2'b00));
        // Checking the start address as well catches a 32-bit wrap of w_end
        w_req_err = (req_load == req_store) || !w_f3_ok ||
                    (req_store && req_func3[2]) ||
                    (req_addr >= C_LIMIT) || (w_end >= C_LIMIT) ||
                    (w_mis && !SPLIT_MISALIGNED);
    end

    // Byte assembly for split loads: merge the current byte, then extend
    always_comb begin
        w_cnt_inc = r_cnt + 2'd1;
        w_acc_ins = r_acc;
        w_acc_ins[{r_cnt, 3'b000} +: 8] = mem_rdata[7:0];
        case (r_func3)
            3'b001:  w_acc_ext = {{16{w_acc_ins[15]}}, w_acc_ins[15:0]};
            3'b101:  w_acc_ext = {16'd0, w_acc_ins[15:0]};
            default: w_acc_ext = w_acc_ins;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_load       = r_load;
        w_mis_q      = r_mis;
        w_func3_q    = r_func3;
        w_addr_q     = r_addr;
        w_wdata_q    = r_wdata;
        w_cnt        = r_cnt;
        w_last       = r_last;
        w_acc        = r_acc;
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_rdata = resp_rdata;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_func3  = mem_func3;
        w_mem_addr   = mem_addr;
        w_mem_wdata  = mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                        w_resp_rdata = 32'd0;
                    end else begin
                        w_state     = ST_ACCESS;
                        w_load      = req_load;
                        w_mis_q     = w_mis;
                        w_func3_q   = req_func3;
                        w_addr_q    = req_addr;
                        w_wdata_q   = req_wdata;
                        w_cnt       = 2'd0;
                        w_last      = w_size_m1;
                        w_acc       = 32'd0;
                        w_mem_read  = req_load;
                        w_mem_write = req_store;
                        w_mem_addr  = req_addr;
                        if (w_mis) begin
                            w_mem_func3 = req_load ? C_F3_LBU : C_F3_SB;
                            w_mem_wdata = {24'd0, req_wdata[7:0]};
                        end else begin
                            w_mem_func3 = req_func3;
                            w_mem_wdata = req_wdata;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!r_mis || (r_cnt == r_last)) begin
                    w_state      = ST_RESP;
                    w_resp_valid = 1'b1;
                    if (!r_load)
                        w_resp_rdata = 32'd0;
                    else if (r_mis)
                        w_resp_rdata = w_acc_ext;
                    else
                        w_resp_rdata = mem_rdata;
                end else begin
                    w_cnt       = w_cnt_inc;
                    w_acc       = w_acc_ins;
                    w_mem_read  = r_load;
                    w_mem_write = !r_load;
                    w_mem_addr  = r_addr + {30'd0, w_cnt_inc};
                    w_mem_wdata = {24'd0, r_wdata[{w_cnt_inc, 3'b000} +: 8]};
                end
            end
            default: w_state = ST_IDLE;
        endcase

        w_req_ready = (w_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_load     <= 1'b0;
            r_mis      <= 1'b0;
            r_func3    <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_cnt      <= 2'd0;
            r_last     <= 2'd0;
            r_acc      <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_func3  <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            r_state    <= w_state;
            r_load     <= w_load;
            r_mis      <= w_mis_q;
            r_func3    <= w_func3_q;
            r_addr     <= w_addr_q;
            r_wdata    <= w_wdata_q;
            r_cnt      <= w_cnt;
            r_last     <= w_last;
            r_acc      <= w_acc;
            req_ready  <= w_req_ready;
            resp_valid <= w_resp_valid;
            resp_err   <= w_resp_err;
            resp_rdata <= w_resp_rdata;
            mem_read   <= w_mem_read;
            mem_write  <= w_mem_write;
            mem_func3  <= w_mem_func3;
            mem_addr   <= w_mem_addr;
            mem_wdata  <= w_mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_sequencer.sv
// ============================================================================
// Module  : tb_lsu_mem_sequencer
// Brief   : Directed vector bench with a byte-array memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid1 = 1'b0, req_valid0 = 1'b0;
    logic        req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

    logic        req_ready1, resp_valid1, resp_err1, mem_read1, mem_write1;
    logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [2:0]  mem_func3_1;
    logic        req_ready0, resp_valid0, resp_err0, mem_read0, mem_write0;
    logic [31:0] resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic [2:0]  mem_func3_0;

    always #5 clk = ~clk;

    lsu_mem_sequencer #(.MEM_BYTES(256), .SPLIT_MISALIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_load(req_load), .req_store(req_store), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_func3(mem_func3_1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

    lsu_mem_sequencer #(.MEM_BYTES(256), .SPLIT_MISALIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_load(req_load), .req_store(req_store), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .mem_read(mem_read0),
        .mem_write(mem_write0), .mem_func3(mem_func3_0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

    // Memory model: DUT1 reads and writes; DUT0 reads only, its writes are counted
    logic [7:0] mem [256];

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++)
            b[i] = ((a + 32'(i)) < 32'd256) ? mem[8'(a + 32'(i))] : 8'h00;
        case (f3)
            3'b000:  return {{24{b[0][7]}}, b[0]};
            3'b100:  return {24'd0, b[0]};
            3'b001:  return {{16{b[1][7]}}, b[1], b[0]};
            3'b101:  return {16'd0, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    always_comb begin
        mem_rdata1 = mem_rd(mem_addr1, mem_func3_1);
        mem_rdata0 = mem_rd(mem_addr0, mem_func3_0);
    end

    int rd1 = 0, wr1 = 0, wr0 = 0, acnt = 0;
    logic [31:0] alog [64];
    logic [2:0]  flog [64];

    always @(posedge clk) begin
        if (mem_write1) begin
            mem[8'(mem_addr1)] <= mem_wdata1[7:0];
            if (mem_func3_1[1:0] != 2'b00) mem[8'(mem_addr1 + 1)] <= mem_wdata1[15:8];
            if (mem_func3_1[1:0] == 2'b10) begin
                mem[8'(mem_addr1 + 2)] <= mem_wdata1[23:16];
                mem[8'(mem_addr1 + 3)] <= mem_wdata1[31:24];
            end
        end
        if (mem_read1) rd1 = rd1 + 1;
        if (mem_write1) wr1 = wr1 + 1;
        if (mem_write0) wr0 = wr0 + 1;
        if (mem_read1 || mem_write1) begin
            alog[acnt % 64] = mem_addr1;
            flog[acnt % 64] = mem_func3_1;
            acnt = acnt + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [2:0]  exp_mf3;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int lat,
                                input int rd, input int wr, input logic [2:0] mf3);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        v.exp_rd = rd; v.exp_wr = wr; v.exp_mf3 = mf3;
        return v;
    endfunction

    // One request on the chosen DUT; returns response cycle relative to accept (0 = none)
    task automatic issue(input bit sel, input vec_t v, output int lat,
                         output logic [31:0] rdata, output logic err);
        lat = 0; rdata = 32'hDEAD_BEEF; err = 1'bx;
        @(negedge clk);
        req_load = v.ld; req_store = v.st; req_func3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0; req_valid0 = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (sel ? resp_valid1 : resp_valid0) begin
                lat = c;
                rdata = sel ? resp_rdata1 : resp_rdata0;
                err = sel ? resp_err1 : resp_err0;
                chk("ready_low_in_resp", 32'(sel ? req_ready1 : req_ready0), 32'd0);
            end
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(sel ? resp_valid1 : resp_valid0), 32'd0);
    endtask

    initial begin
        int lat, rd_s, wr_s, a_s, n_acc;
        logic [31:0] rdata;
        logic err;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h11;
        for (int i = 12; i < 16; i++) mem[i] = 8'hFF;
        mem[4] = 8'h09;

        vecs[0]  = mk(1, 0, 3'b010, 0,   0, 32'h0000_0011, 0, 2, 1, 0, 3'b010);
        vecs[1]  = mk(1, 0, 3'b001, 13,  0, 32'hFFFF_FFFF, 0, 3, 2, 0, 3'b100);
        vecs[2]  = mk(1, 0, 3'b101, 13,  0, 32'h0000_FFFF, 0, 3, 2, 0, 3'b100);
        vecs[3]  = mk(0, 1, 3'b010, 5,   32'hA1B2_C3D4, 0, 0, 5, 0, 4, 3'b000);
        vecs[4]  = mk(1, 0, 3'b010, 4,   0, 32'hB2C3_D409, 0, 2, 1, 0, 3'b010);
        vecs[5]  = mk(1, 0, 3'b010, 254, 0, 0, 1, 1, 0, 0, 3'b000);
        vecs[6]  = mk(1, 0, 3'b011, 0,   0, 0, 1, 1, 0, 0, 3'b000);
        vecs[7]  = mk(1, 0, 3'b000, 12,  0, 32'hFFFF_FFFF, 0, 2, 1, 0, 3'b000);
        vecs[8]  = mk(1, 0, 3'b100, 12,  0, 32'h0000_00FF, 0, 2, 1, 0, 3'b100);
        vecs[9]  = mk(0, 1, 3'b100, 0,   0, 0, 1, 1, 0, 0, 3'b000);
        vecs[10] = mk(1, 1, 3'b010, 0,   0, 0, 1, 1, 0, 0, 3'b000);
        vecs[11] = mk(0, 0, 3'b010, 0,   0, 0, 1, 1, 0, 0, 3'b000);
        vecs[12] = mk(0, 1, 3'b001, 16,  32'h0000_1234, 0, 0, 2, 0, 1, 3'b001);
        vecs[13] = mk(1, 0, 3'b001, 16,  0, 32'h0000_1234, 0, 2, 1, 0, 3'b001);
        vecs[14] = mk(1, 0, 3'b010, 253, 0, 0, 1, 1, 0, 0, 3'b000);
        vecs[15] = mk(1, 0, 3'b010, 252, 0, 0, 0, 2, 1, 0, 3'b010);
        vecs[16] = mk(1, 0, 3'b010, 6,   0, 32'h00A1_B2C3, 0, 5, 4, 0, 3'b100);
        vecs[17] = mk(1, 0, 3'b001, 7,   0, 32'hFFFF_A1B2, 0, 3, 2, 0, 3'b100);
        vecs[18] = mk(0, 1, 3'b001, 21,  32'h0000_BEEF, 0, 0, 3, 0, 2, 3'b000);
        vecs[19] = mk(1, 0, 3'b101, 21,  0, 32'h0000_BEEF, 0, 3, 2, 0, 3'b100);
        vecs[20] = mk(1, 0, 3'b010, 32'hFFFF_FFFE, 0, 0, 1, 1, 0, 0, 3'b000);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready1), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid1), 32'd0);
        chk("rst_resp_err", 32'(resp_err1), 32'd0);
        chk("rst_resp_rdata", resp_rdata1, 32'd0);
        chk("rst_mem_strobes", {30'd0, mem_read1, mem_write1}, 32'd0);
        chk("rst_mem_bus", mem_addr1 | mem_wdata1 | 32'(mem_func3_1), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            rd_s = rd1; wr_s = wr1; a_s = acnt;
            issue(1'b1, vecs[i], lat, rdata, err);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_reads", i), 32'(rd1 - rd_s), 32'(vecs[i].exp_rd));
            chk($sformatf("v%0d_writes", i), 32'(wr1 - wr_s), 32'(vecs[i].exp_wr));
            n_acc = vecs[i].exp_rd + vecs[i].exp_wr;
            if (n_acc > 0 && (acnt - a_s) == n_acc) begin
                chk($sformatf("v%0d_first_addr", i), alog[a_s % 64], vecs[i].addr);
                chk($sformatf("v%0d_last_addr", i), alog[(acnt - 1) % 64],
                    vecs[i].addr + 32'(n_acc - 1));
                chk($sformatf("v%0d_mem_func3", i), 32'(flog[a_s % 64]), 32'(vecs[i].exp_mf3));
            end
        end

        // Split disabled: misaligned SH is an error with no write
        wr_s = wr0;
        issue(1'b0, mk(0, 1, 3'b001, 1, 32'h0000_5566, 0, 1, 1, 0, 0, 3'b000), lat, rdata, err);
        chk("nosplit_lat", 32'(lat), 32'd1);
        chk("nosplit_err", 32'(err), 32'd1);
        chk("nosplit_no_write", 32'(wr0 - wr_s), 32'd0);

        // Split disabled: aligned LW held valid is accepted every third cycle
        @(negedge clk);
        req_load = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'd0;
        req_valid0 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready0), 32'((c % 3) == 0));
            chk($sformatf("b2b_resp_c%0d", c), 32'(resp_valid0), 32'((c % 3) == 2));
            if ((c % 3) == 2) chk($sformatf("b2b_rdata_c%0d", c), resp_rdata0, 32'h0000_0011);
        end
        req_valid0 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the third byte of a split SW at 5
        req_load = 1'b0; req_store = 1'b1; req_func3 = 3'b010;
        req_addr = 32'd5; req_wdata = 32'h5566_7788;
        req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_third_byte_addr", mem_addr1, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("rstmid_write_low", 32'(mem_write1), 32'd0);
        chk("rstmid_ready", 32'(req_ready1), 32'd1);
        chk("rstmid_resp_valid", 32'(resp_valid1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid1) lat = 1;
        end
        chk("rstmid_no_resp", 32'(lat), 32'd0);
        chk("rstmid_mem5", 32'(mem[5]), 32'h88);
        chk("rstmid_mem6", 32'(mem[6]), 32'h77);
        chk("rstmid_mem7", 32'(mem[7]), 32'hB2);
        chk("rstmid_mem8", 32'(mem[8]), 32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
